// File: rtl/dest_reg_scoreboard_pkg.sv
// Shared constants and types for the destination-register scoreboard (package sb_pkg).
package sb_pkg;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 32;
   localparam int CNT_W    = 2;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef logic [ADDR_W-1:0] reg_addr_t;

   localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/dest_reg_scoreboard_counter.sv
// Per-register pending-write counter: saturating up/down, simultaneous inc+dec holds.
module sb_counter
   import sb_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic inc,
   input  logic dec,
   output logic nonzero,
   output logic at_max,
   output logic is_one,
   output logic underflow
);
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc && !dec) begin
         if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      end else if (dec && !inc) begin
         if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   // A writeback with nothing pending is an error even if an issue lands the same cycle.
   assign underflow = dec && (cnt_q == '0);
   assign nonzero   = (cnt_q != '0);
   assign at_max    = (cnt_q == CNT_MAX);
   assign is_one    = (cnt_q == CNT_W'(1));
endmodule

// File: rtl/dest_reg_scoreboard.sv
// Destination-register scoreboard: RAW/saturation stall, per-register pending counters, sticky underflow.
// Optional macro SB_WB_BYPASS_EN lets a same-cycle final writeback clear a source hazard.
module dest_reg_scoreboard
   import sb_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                issue_valid,
   output logic                issue_ready,
   input  logic                issue_we,
   input  logic [ADDR_W-1:0]   issue_dst,
   input  logic [ADDR_W-1:0]   issue_rs,
   input  logic [ADDR_W-1:0]   issue_rt,
   input  logic                issue_use_rs,
   input  logic                issue_use_rt,
   input  logic                wb_valid,
   input  logic [ADDR_W-1:0]   wb_dst,
   output logic [NUM_REGS-1:0] busy_vec,
   output logic                raw_stall,
   output logic                sat_stall,
   output logic                err_underflow
);
   logic [NUM_REGS-1:0] nz, at_max, is_one, uf;
   logic accept, rs_busy, rt_busy, wb_to_dst;
   logic err_q, err_d;

   assign nz[0]     = 1'b0;
   assign at_max[0] = 1'b0;
   assign is_one[0] = 1'b0;
   assign uf[0]     = 1'b0;

   genvar gi;
   generate
      for (gi = 1; gi < NUM_REGS; gi++) begin : g_cnt
         logic inc, dec;
         assign inc = accept && issue_we && (issue_dst == reg_addr_t'(gi));
         assign dec = wb_valid && (wb_dst == reg_addr_t'(gi));
         sb_counter u_cnt (
            .clk       (clk),
            .reset     (reset),
            .inc       (inc),
            .dec       (dec),
            .nonzero   (nz[gi]),
            .at_max    (at_max[gi]),
            .is_one    (is_one[gi]),
            .underflow (uf[gi])
         );
      end
   endgenerate

   always_comb begin
`ifdef SB_WB_BYPASS_EN
      rs_busy = nz[issue_rs] && !(is_one[issue_rs] && wb_valid && (wb_dst == issue_rs));
      rt_busy = nz[issue_rt] && !(is_one[issue_rt] && wb_valid && (wb_dst == issue_rt));
`else
      rs_busy = nz[issue_rs];
      rt_busy = nz[issue_rt];
`endif
   end

   assign wb_to_dst = wb_valid && (wb_dst == issue_dst);

   assign raw_stall = !reset && issue_valid &&
                      ((issue_use_rs && (issue_rs != REG_ZERO) && rs_busy) ||
                       (issue_use_rt && (issue_rt != REG_ZERO) && rt_busy));
   assign sat_stall = !reset && issue_valid && issue_we && (issue_dst != REG_ZERO) &&
                      at_max[issue_dst] && !wb_to_dst;
   assign issue_ready = !reset && !raw_stall && !sat_stall;
   assign accept      = issue_valid && issue_ready;

   assign err_d = err_q || (|uf);

   always_ff @(posedge clk) begin
      if (reset) err_q <= 1'b0;
      else       err_q <= err_d;
   end

   assign err_underflow = err_q;
   assign busy_vec      = nz;
endmodule

// File: tb/tb_dest_reg_scoreboard.sv
// Table-driven bench for dest_reg_scoreboard; expectations follow SB_WB_BYPASS_EN when defined.
module tb_dest_reg_scoreboard;
`ifdef SB_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        issue_valid = 1'b0, issue_we = 1'b0, issue_use_rs = 1'b0, issue_use_rt = 1'b0;
   logic [4:0]  issue_dst = '0, issue_rs = '0, issue_rt = '0, wb_dst = '0;
   logic        wb_valid = 1'b0;
   logic        issue_ready, raw_stall, sat_stall, err_underflow;
   logic [31:0] busy_vec;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   dest_reg_scoreboard dut (
      .clk           (clk),
      .reset         (reset),
      .issue_valid   (issue_valid),
      .issue_ready   (issue_ready),
      .issue_we      (issue_we),
      .issue_dst     (issue_dst),
      .issue_rs      (issue_rs),
      .issue_rt      (issue_rt),
      .issue_use_rs  (issue_use_rs),
      .issue_use_rt  (issue_use_rt),
      .wb_valid      (wb_valid),
      .wb_dst        (wb_dst),
      .busy_vec      (busy_vec),
      .raw_stall     (raw_stall),
      .sat_stall     (sat_stall),
      .err_underflow (err_underflow)
   );

   typedef struct {
      bit         rst, v, we;
      logic [4:0] dst, rs, rt;
      bit         urs, urt, wbv;
      logic [4:0] wbd;
      bit         e_rdy, e_raw, e_sat;
      logic [31:0] e_busy;
      bit         e_err;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input bit rst, v, we, input logic [4:0] dst, rs, rt,
                      input bit urs, urt, wbv, input logic [4:0] wbd,
                      input bit er, eraw, esat, input logic [31:0] eb, input bit ee);
      vec_t t;
      t.rst = rst; t.v = v; t.we = we; t.dst = dst; t.rs = rs; t.rt = rt;
      t.urs = urs; t.urt = urt; t.wbv = wbv; t.wbd = wbd;
      t.e_rdy = er; t.e_raw = eraw; t.e_sat = esat; t.e_busy = eb; t.e_err = ee;
      vecs.push_back(t);
   endtask

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input vec_t t);
      reset = t.rst; issue_valid = t.v; issue_we = t.we; issue_dst = t.dst;
      issue_rs = t.rs; issue_rt = t.rt; issue_use_rs = t.urs; issue_use_rt = t.urt;
      wb_valid = t.wbv; wb_dst = t.wbd;
   endtask

   task automatic check_all(input vec_t t, input int idx);
      chk("issue_ready", idx, 32'(issue_ready), 32'(t.e_rdy));
      chk("raw_stall", idx, 32'(raw_stall), 32'(t.e_raw));
      chk("sat_stall", idx, 32'(sat_stall), 32'(t.e_sat));
      chk("busy_vec", idx, busy_vec, t.e_busy);
      chk("err_underflow", idx, 32'(err_underflow), 32'(t.e_err));
      $display("step %0d rst=%0b v=%0b we=%0b dst=%0d rs=%0d rt=%0d wb=%0b/%0d -> rdy=%0b raw=%0b sat=%0b busy=%08h err=%0b",
               idx, t.rst, t.v, t.we, t.dst, t.rs, t.rt, t.wbv, t.wbd,
               issue_ready, raw_stall, sat_stall, busy_vec, err_underflow);
   endtask

   initial begin
      vec_t t;
      //   rst v we dst rs rt urs urt wbv wbd | rdy raw sat busy err
      add(1, 1, 1, 8, 0, 0, 0, 0, 0, 0,   0, 0, 0, 32'h0, 0);
      add(0, 1, 1, 8, 0, 0, 0, 0, 0, 0,   1, 0, 0, 32'h0, 0);
      add(0, 1, 0, 0, 8, 0, 1, 0, 0, 0,   0, 1, 0, 32'h100, 0);
      add(0, 1, 0, 0, 8, 0, 1, 0, 1, 8,   BYP, !BYP, 0, 32'h100, 0);
      add(0, 1, 0, 0, 8, 0, 1, 0, 0, 0,   1, 0, 0, 32'h0, 0);
      // saturation on reg 5
      add(0, 1, 1, 5, 0, 0, 0, 0, 0, 0,   1, 0, 0, 32'h0, 0);
      add(0, 1, 1, 5, 0, 0, 0, 0, 0, 0,   1, 0, 0, 32'h20, 0);
      add(0, 1, 1, 5, 0, 0, 0, 0, 0, 0,   1, 0, 0, 32'h20, 0);
      add(0, 1, 1, 5, 0, 0, 0, 0, 0, 0,   0, 0, 1, 32'h20, 0);
      add(0, 1, 1, 5, 0, 0, 0, 0, 1, 5,   1, 0, 0, 32'h20, 0);
      add(0, 1, 1, 5, 0, 0, 0, 0, 0, 0,   0, 0, 1, 32'h20, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 1, 5,   1, 0, 0, 32'h20, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 1, 5,   1, 0, 0, 32'h20, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 1, 5,   1, 0, 0, 32'h20, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 32'h0, 0);
      // register 0 is never tracked
      for (int i = 0; i < 4; i++) add(0, 1, 1, 0, 0, 0, 1, 1, 0, 0,   1, 0, 0, 32'h0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,   1, 0, 0, 32'h0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 32'h0, 0);
      // same-cycle issue and writeback on reg 9
      add(0, 1, 1, 9, 0, 0, 0, 0, 0, 0,   1, 0, 0, 32'h0, 0);
      add(0, 1, 1, 9, 0, 0, 0, 0, 1, 9,   1, 0, 0, 32'h200, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 32'h200, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 1, 9,   1, 0, 0, 32'h200, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 32'h0, 0);
      // regs 3,7 busy; rt hazard, rs hazard, unused sources
      add(0, 1, 1, 3, 0, 0, 0, 0, 0, 0,   1, 0, 0, 32'h0, 0);
      add(0, 1, 1, 7, 0, 0, 0, 0, 0, 0,   1, 0, 0, 32'h8, 0);
      add(0, 1, 0, 0, 3, 7, 0, 1, 0, 0,   0, 1, 0, 32'h88, 0);
      add(0, 1, 0, 0, 3, 7, 1, 0, 0, 0,   0, 1, 0, 32'h88, 0);
      add(0, 1, 0, 0, 3, 7, 0, 0, 0, 0,   1, 0, 0, 32'h88, 0);
      // underflow on reg 12, then reset mid-flight
      add(0, 0, 0, 0, 0, 0, 0, 0, 1, 12,  1, 0, 0, 32'h88, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 32'h88, 1);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 32'h88, 1);
      add(1, 1, 0, 0, 3, 0, 1, 0, 0, 0,   0, 0, 0, 32'h88, 1);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 32'h0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 1, 3,   1, 0, 0, 32'h0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 32'h0, 1);
      add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 32'h0, 1);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 32'h0, 0);

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i]);
         #1;
         check_all(vecs[i], i);
      end

      // Dependent waiting on reg 20 while its only pending write retires.
      t = vecs[vecs.size()-1];
      t.v = 1; t.we = 1; t.dst = 20;
      @(negedge clk); drive(t); #1;
      chk("seq_issue20_ready", 100, 32'(issue_ready), 32'd1);
      t.we = 0; t.rs = 20; t.urs = 1; t.wbv = 1; t.wbd = 20;
      @(negedge clk); drive(t); #1;
      chk("seq_dep_ready_wb_cycle", 101, 32'(issue_ready), 32'(BYP));
      chk("seq_dep_raw_wb_cycle", 101, 32'(raw_stall), 32'(!BYP));
      $display("seq dep on r20 at wb cycle: rdy=%0b raw=%0b", issue_ready, raw_stall);
      t.wbv = 0;
      @(negedge clk); drive(t); #1;
      chk("seq_dep_ready_next", 102, 32'(issue_ready), 32'd1);
      chk("seq_busy_clear", 102, busy_vec, 32'h0);
      $display("seq dep on r20 after wb: rdy=%0b busy=%08h", issue_ready, busy_vec);

      // WAW: two writes to reg 20 need two writebacks.
      t.urs = 0; t.rs = 0; t.we = 1; t.dst = 20;
      @(negedge clk); drive(t);
      @(negedge clk); drive(t);
      t.v = 0; t.we = 0; t.wbv = 1; t.wbd = 20;
      @(negedge clk); drive(t); #1;
      chk("waw_busy_two", 103, busy_vec, 32'h0010_0000);
      @(negedge clk); drive(t); #1;
      chk("waw_busy_one", 104, busy_vec, 32'h0010_0000);
      t.wbv = 0;
      @(negedge clk); drive(t); #1;
      chk("waw_busy_zero", 105, busy_vec, 32'h0);
      chk("waw_no_err", 105, 32'(err_underflow), 32'd0);
      $display("seq WAW r20: busy=%08h err=%0b", busy_vec, err_underflow);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
